// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: forward-select encodings and the
// layout of the 8-bit control bundle carried from ID into EX.
package id_ex_stage_pkg;

  // Operand-mux select; 2'b11 is never produced.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned CTRL_W = 8;
  localparam int unsigned FUNCT_W = 10;

  // Control bundle bit positions: {reg_write, mem_to_reg, mem_read,
  // mem_write, alu_src, branch, alu_op[1:0]}.
  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_MEM_READ   = 5;
  localparam int unsigned CTRL_MEM_WRITE  = 4;
  localparam int unsigned CTRL_ALU_SRC    = 3;
  localparam int unsigned CTRL_BRANCH     = 2;
  localparam int unsigned CTRL_ALU_OP_HI  = 1;
  localparam int unsigned CTRL_ALU_OP_LO  = 0;

endpackage

// File: rtl/id_ex_stage_ex_forward_unit.sv
// Forward-select generation for one EX operand. EX/MEM wins over MEM/WB;
// register x0 is never forwarded.
module ex_forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] ex_rs_i,
  input  logic [REGW-1:0] exmem_rd_i,
  input  logic            exmem_reg_write_i,
  input  logic [REGW-1:0] memwb_rd_i,
  input  logic            memwb_reg_write_i,
  output logic [1:0]      fwd_o
);

  fwd_sel_e sel;

  // Priority select: youngest producer first.
  always_comb begin
    sel = FWD_REG;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs_i))
      sel = FWD_EXMEM;
    else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs_i))
      sel = FWD_MEMWB;
  end

  assign fwd_o = sel;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand
// forward-select generation.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [REGW-1:0]    id_rs1_i,
  input  logic [REGW-1:0]    id_rs2_i,
  input  logic [REGW-1:0]    id_rd_i,
  input  logic [XLEN-1:0]    id_rs1_data_i,
  input  logic [XLEN-1:0]    id_rs2_data_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic [FUNCT_W-1:0] id_funct_i,
  input  logic [CTRL_W-1:0]  id_ctrl_i,
  input  logic [REGW-1:0]    exmem_rd_i,
  input  logic               exmem_reg_write_i,
  input  logic [REGW-1:0]    memwb_rd_i,
  input  logic               memwb_reg_write_i,
  output logic               ex_valid_o,
  output logic [REGW-1:0]    ex_rs1_o,
  output logic [REGW-1:0]    ex_rs2_o,
  output logic [REGW-1:0]    ex_rd_o,
  output logic [XLEN-1:0]    ex_rs1_data_o,
  output logic [XLEN-1:0]    ex_rs2_data_o,
  output logic [XLEN-1:0]    ex_imm_o,
  output logic [FUNCT_W-1:0] ex_funct_o,
  output logic [CTRL_W-1:0]  ex_ctrl_o,
  output logic [1:0]         fwd_a_o,
  output logic [1:0]         fwd_b_o,
  output logic               stall_o
);

  logic load_use;

  // Load in EX whose destination is read by the instruction in ID. Both
  // sources are compared regardless of instruction format.
  always_comb begin
    load_use = ex_valid_o && ex_ctrl_o[CTRL_MEM_READ] && (ex_rd_o != '0) &&
               id_valid_i && ((ex_rd_o == id_rs1_i) || (ex_rd_o == id_rs2_i));
  end

  // A held or flushed stage must not also freeze the front end.
  always_comb begin
    stall_o = load_use && !flush_i && !hold_i;
  end

  // Pipeline register: reset > hold > flush/hazard bubble > load.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_funct_o    <= '0;
      ex_ctrl_o     <= '0;
    end else if (!hold_i) begin
      if (flush_i || load_use) begin
        ex_valid_o    <= 1'b0;
        ex_rs1_o      <= '0;
        ex_rs2_o      <= '0;
        ex_rd_o       <= '0;
        ex_rs1_data_o <= '0;
        ex_rs2_data_o <= '0;
        ex_imm_o      <= '0;
        ex_funct_o    <= '0;
        ex_ctrl_o     <= '0;
      end else begin
        ex_valid_o    <= id_valid_i;
        ex_rs1_o      <= id_rs1_i;
        ex_rs2_o      <= id_rs2_i;
        ex_rd_o       <= id_rd_i;
        ex_rs1_data_o <= id_rs1_data_i;
        ex_rs2_data_o <= id_rs2_data_i;
        ex_imm_o      <= id_imm_i;
        ex_funct_o    <= id_funct_i;
        ex_ctrl_o     <= id_valid_i ? id_ctrl_i : '0;
      end
    end
  end

  ex_forward_unit #(.REGW(REGW)) u_fwd_a (
    .ex_rs_i           (ex_rs1_o),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .fwd_o             (fwd_a_o)
  );

  ex_forward_unit #(.REGW(REGW)) u_fwd_b (
    .ex_rs_i           (ex_rs2_o),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .fwd_o             (fwd_b_o)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed per-cycle vectors push their
// hand-computed expectations; a negedge monitor pops and compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [7:0]  ctrl;
  } instr_t;

  typedef struct {
    string      name;
    instr_t     ex;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
  } exp_t;

  localparam instr_t BUB   = '0;
  localparam instr_t ADD5  = '{valid:1'b1, rs1:5'd1, rs2:5'd2, rd:5'd5, d1:32'd11, d2:32'd22,
                               imm:32'd0, funct:10'h000, ctrl:8'h82};
  localparam instr_t USE5  = '{valid:1'b1, rs1:5'd5, rs2:5'd5, rd:5'd6, d1:32'h55, d2:32'h66,
                               imm:32'd0, funct:10'h100, ctrl:8'h82};
  localparam instr_t INV   = '{valid:1'b0, rs1:5'd7, rs2:5'd7, rd:5'd3, d1:32'd1, d2:32'd2,
                               imm:32'd3, funct:10'h3ff, ctrl:8'hff};
  localparam instr_t INV_L = '{valid:1'b0, rs1:5'd7, rs2:5'd7, rd:5'd3, d1:32'd1, d2:32'd2,
                               imm:32'd3, funct:10'h3ff, ctrl:8'h00};
  localparam instr_t LW7   = '{valid:1'b1, rs1:5'd3, rs2:5'd0, rd:5'd7, d1:32'h1000, d2:32'd0,
                               imm:32'd4, funct:10'h002, ctrl:8'hE8};
  localparam instr_t DEP7  = '{valid:1'b1, rs1:5'd8, rs2:5'd7, rd:5'd9, d1:32'h88, d2:32'h77,
                               imm:32'd0, funct:10'h000, ctrl:8'h82};
  localparam instr_t LW0   = '{valid:1'b1, rs1:5'd0, rs2:5'd0, rd:5'd0, d1:32'd0, d2:32'd0,
                               imm:32'd8, funct:10'h002, ctrl:8'hE8};
  localparam instr_t USE0  = '{valid:1'b1, rs1:5'd0, rs2:5'd0, rd:5'd4, d1:32'd0, d2:32'd0,
                               imm:32'd0, funct:10'h000, ctrl:8'h82};

  logic        clk;
  logic        rst, hold, flush;
  instr_t      id;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_we, memwb_we;
  logic        ex_valid;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_d1, ex_d2, ex_imm;
  logic [9:0]  ex_funct;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .hold_i            (hold),
    .flush_i           (flush),
    .id_valid_i        (id.valid),
    .id_rs1_i          (id.rs1),
    .id_rs2_i          (id.rs2),
    .id_rd_i           (id.rd),
    .id_rs1_data_i     (id.d1),
    .id_rs2_data_i     (id.d2),
    .id_imm_i          (id.imm),
    .id_funct_i        (id.funct),
    .id_ctrl_i         (id.ctrl),
    .exmem_rd_i        (exmem_rd),
    .exmem_reg_write_i (exmem_we),
    .memwb_rd_i        (memwb_rd),
    .memwb_reg_write_i (memwb_we),
    .ex_valid_o        (ex_valid),
    .ex_rs1_o          (ex_rs1),
    .ex_rs2_o          (ex_rs2),
    .ex_rd_o           (ex_rd),
    .ex_rs1_data_o     (ex_d1),
    .ex_rs2_data_o     (ex_d2),
    .ex_imm_o          (ex_imm),
    .ex_funct_o        (ex_funct),
    .ex_ctrl_o         (ex_ctrl),
    .fwd_a_o           (fwd_a),
    .fwd_b_o           (fwd_b),
    .stall_o           (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue what the
  // DUT should show during that cycle (state from the previous edge).
  task automatic step(input string name, input logic r, input logic h, input logic f,
                      input instr_t i, input logic [4:0] xr, input logic xw,
                      input logic [4:0] wr, input logic ww, input logic chk,
                      input instr_t e_ex, input logic [1:0] e_fa, input logic [1:0] e_fb,
                      input logic e_st);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hold = h; flush = f; id = i;
    exmem_rd = xr; exmem_we = xw; memwb_rd = wr; memwb_we = ww;
    if (chk) begin
      e.name = name; e.ex = e_ex; e.fa = e_fa; e.fb = e_fb; e.st = e_st;
      sb.push_back(e);
    end
  endtask

  // Monitor: compare the stage outputs against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t   e;
      instr_t act;
      e = sb.pop_front();
      act = '{valid:ex_valid, rs1:ex_rs1, rs2:ex_rs2, rd:ex_rd, d1:ex_d1, d2:ex_d2,
              imm:ex_imm, funct:ex_funct, ctrl:ex_ctrl};
      vectors++;
      if (act !== e.ex) begin
        miscompares++;
        $display("FAIL %s/ex: got %h want %h", e.name, act, e.ex);
      end
      vectors++;
      if ({fwd_a, fwd_b} !== {e.fa, e.fb}) begin
        miscompares++;
        $display("FAIL %s/fwd: got a=%b b=%b want a=%b b=%b", e.name, fwd_a, fwd_b, e.fa, e.fb);
      end
      vectors++;
      if (stall !== e.st) begin
        miscompares++;
        $display("FAIL %s/stall: got %b want %b", e.name, stall, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; hold = 1'b0; flush = 1'b0; id = ADD5;
    exmem_rd = '0; exmem_we = 1'b0; memwb_rd = '0; memwb_we = 1'b0;
    //            name        rst  hold flush id    xrd    xw    wrd    ww    chk   ex     fa     fb     st
    step("rst_in",   1'b0, 1'b0, 1'b0, ADD5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, BUB,   2'b00, 2'b00, 1'b0);
    step("reset",    1'b1, 1'b0, 1'b0, ADD5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, BUB,   2'b00, 2'b00, 1'b0);
    step("ld_add",   1'b1, 1'b0, 1'b0, USE5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, ADD5,  2'b00, 2'b00, 1'b0);
    step("fwd_xm",   1'b1, 1'b1, 1'b0, INV,  5'd5, 1'b1, 5'd0, 1'b0, 1'b1, USE5,  2'b10, 2'b10, 1'b0);
    step("fwd_both", 1'b1, 1'b1, 1'b0, INV,  5'd5, 1'b1, 5'd5, 1'b1, 1'b1, USE5,  2'b10, 2'b10, 1'b0);
    step("fwd_mw",   1'b1, 1'b0, 1'b0, INV,  5'd0, 1'b0, 5'd5, 1'b1, 1'b1, USE5,  2'b01, 2'b01, 1'b0);
    step("invalid",  1'b1, 1'b0, 1'b0, LW7,  5'd0, 1'b0, 5'd0, 1'b0, 1'b1, INV_L, 2'b00, 2'b00, 1'b0);
    step("lu_stall", 1'b1, 1'b0, 1'b0, DEP7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, LW7,   2'b00, 2'b00, 1'b1);
    step("lu_bub",   1'b1, 1'b0, 1'b0, DEP7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, BUB,   2'b00, 2'b00, 1'b0);
    step("lu_dep",   1'b1, 1'b0, 1'b0, LW0,  5'd0, 1'b0, 5'd7, 1'b1, 1'b1, DEP7,  2'b00, 2'b01, 1'b0);
    step("x0",       1'b1, 1'b0, 1'b0, USE0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, LW0,   2'b00, 2'b00, 1'b0);
    step("x0_use",   1'b1, 1'b0, 1'b0, LW7,  5'd0, 1'b0, 5'd0, 1'b0, 1'b1, USE0,  2'b00, 2'b00, 1'b0);
    step("flush_hz", 1'b1, 1'b0, 1'b1, DEP7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, LW7,   2'b00, 2'b00, 1'b0);
    step("flush_bb", 1'b1, 1'b0, 1'b0, LW7,  5'd0, 1'b0, 5'd0, 1'b0, 1'b1, BUB,   2'b00, 2'b00, 1'b0);
    step("hold_hz1", 1'b1, 1'b1, 1'b0, DEP7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, LW7,   2'b00, 2'b00, 1'b0);
    step("hold_hz2", 1'b1, 1'b1, 1'b0, DEP7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, LW7,   2'b00, 2'b00, 1'b0);
    step("hold_hz3", 1'b1, 1'b1, 1'b0, DEP7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, LW7,   2'b00, 2'b00, 1'b0);
    step("release",  1'b1, 1'b0, 1'b0, DEP7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, LW7,   2'b00, 2'b00, 1'b1);
    step("rel_bub",  1'b1, 1'b0, 1'b0, DEP7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, BUB,   2'b00, 2'b00, 1'b0);
    step("rst_hold", 1'b0, 1'b1, 1'b0, ADD5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, DEP7,  2'b00, 2'b01, 1'b0);
    step("rst_done", 1'b1, 1'b1, 1'b0, ADD5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, BUB,   2'b00, 2'b00, 1'b0);
    step("held_bub", 1'b1, 1'b0, 1'b0, ADD5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, BUB,   2'b00, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the five-stage RV32I core, with load-use hazard detection and EX operand forward-select generation. Latches decoded operands and control from ID, inserts bubbles on load-use hazards, branch flush or external hold, and drives the 2-bit selects of the two EX-stage 4:1 32-bit operand muxes. Sits between the decoder/register file and the EX-stage forwarding muxes and ALU.

## Interface
- Parameters
- XLEN, 32, datapath width.
- REGW, 5, register index width.
- Ports
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- hold_i  in  1  freeze the whole stage (memory stall).
- flush_i  in  1  kill the ID instruction (taken branch/jump).
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i, id_rs2_i, id_rd_i  in  REGW each  register indices.
- id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN each  operands and immediate.
- id_funct_i  in  10  {funct7, funct3}.
- id_ctrl_i  in  8  {reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch, alu_op[1:0]}.
- exmem_rd_i  in  REGW; exmem_reg_write_i  in  1  EX/MEM destination.
- memwb_rd_i  in  REGW; memwb_reg_write_i  in  1  MEM/WB destination.
- ex_valid_o  out  1; ex_rs1_o, ex_rs2_o, ex_rd_o  out  REGW; ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN; ex_funct_o  out  10; ex_ctrl_o  out  8.
- fwd_a_o, fwd_b_o  out  2  operand-A/B mux selects.
- stall_o  out  1  hold PC and IF/ID this cycle.

## Operation
- Registered state: every ex_* output. Reset value of all: 0 (bubble; x0 fields).
- Next-state priority, highest first: reset, hold_i (keep all), flush_i (bubble), load-use hazard (bubble), load (capture id_* inputs).
- Bubble: ex_valid_o=0, ex_ctrl_o=0, all other ex_* fields 0.
- Load captures all id_*; if id_valid_i=0, ctrl is forced to 0 and valid to 0.
- Load-use hazard = ex_valid_o & ex_ctrl_o.mem_read & ex_rd_o≠0 & id_valid_i & (ex_rd_o==id_rs1_i | ex_rd_o==id_rs2_i). Compare both sources regardless of instruction format.
- stall_o = hazard & ~flush_i & ~hold_i (combinational).
- Forward select, per operand, from latched ex_rsN_o: 2'b10 if exmem_reg_write_i & exmem_rd_i≠0 & exmem_rd_i==ex_rsN_o; else 2'b01 if memwb_reg_write_i & memwb_rd_i≠0 & memwb_rd_i==ex_rsN_o; else 2'b00. EX/MEM beats MEM/WB. 2'b11 never driven. Selects valid during hold too (pure function of current state and inputs).
- Mux mapping: 00 register data, 01 MEM/WB result, 10 EX/MEM ALU result.
- Register x0 never forwarded and never triggers a hazard.

## Timing
- Latency: one cycle ID→EX outputs. fwd_*_o and stall_o combinational, same cycle.
- Load-use: exactly one bubble; the following cycle the load sits in EX/MEM and the dependent instruction (held in ID) loads with MEM/WB forwarding (01) on its first EX cycle.
- hold_i with hazard: stall_o=0, nothing changes; hazard re-evaluated after release.
- flush_i with hazard: bubble, stall_o=0.
- rst_i low during any of the above: next edge all outputs 0, regardless of hold_i.

## Structure
- Shared package: forward-select constants FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10; control-bundle width 8 and its bit positions.
- One sub-module: ex_forward_unit (combinational, instanced per operand or once for both). Hazard logic and the register stay in id_ex_stage.

## Test plan
- Reset: rst_i=0 one edge with id_* nonzero -> all ex_* 0, fwd 00, stall_o 0.
- ALU chain: `add x5` in EX/MEM (reg_write=1), next instruction rs1=5, rs2=5 in EX -> fwd_a_o=fwd_b_o=2'b10; x5 also in MEM/WB -> still 10.
- Load-use: `lw x7` in EX (mem_read=1), ID rs2=7 -> stall_o=1, next edge bubble; the edge after loads the dependent instruction with fwd_b_o=2'b01.
- x0: EX/MEM rd=0 reg_write=1, ex_rs1=0 -> fwd_a_o=00; `lw x0` in EX, ID rs1=0 -> stall_o=0.
- Priority: hazard plus flush_i=1 -> stall_o=0, bubble; hazard plus hold_i=1 -> stall_o=0, outputs unchanged for 3 held cycles.
- Reset mid-hold: hold_i=1 with valid state, rst_i=0 -> outputs 0 next edge.
